ysyx_24090013_ifu: RTL and testbench
====================================

# ysyx_24090013_ifu

Instruction fetch unit directly upstream of the decode stage. Holds the architectural PC, fetches one 32-bit instruction at a time from instruction memory over a valid/ready request and valid response interface, and presents instruction and PC to decode through a valid/ready handshake. Sequential next-PC (pc+4) or the execute-stage jump target is selected when decode accepts the instruction.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset; must be 4-byte aligned.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ifu_mem_req_valid  out  1  fetch request valid.
- mem_ifu_req_ready  in  1  memory accepts request.
- ifu_mem_req_addr  out  32  fetch address, always equal to the current PC.
- mem_ifu_resp_valid  in  1  response valid, single cycle.
- mem_ifu_resp_data  in  32  fetched instruction.
- mem_ifu_resp_err  in  1  access error, qualified by resp_valid.
- if_id_valid  out  1  instruction/PC valid to decode.
- id_if_ready  in  1  decode consumes the instruction this cycle.
- if_id_inst  out  32  instruction to decode (drives id_inst).
- if_id_pc  out  32  PC of that instruction (drives pc_id_pc).
- ex_if_jump_en  in  1  taken jump/jalr for the instruction being handed over.
- ex_if_jump_pc  in  32  jump target.
- if_fault  out  1  sticky fault flag.
- if_fault_pc  out  32  PC that caused the fault.

## Operation
- States: IDLE, REQ, WAIT, OUT, FAULT. Outputs decoded from registered state; no combinational path from any input to any output.
- IDLE: entered only by reset; next cycle -> REQ.
- REQ: req_valid=1, req_addr=pc. valid&ready -> WAIT. Otherwise stay; addr held stable.
- WAIT: req_valid=0. resp_valid&~resp_err -> latch resp_data into inst register, -> OUT. resp_valid&resp_err -> fault_pc<=pc, -> FAULT.
- OUT: if_id_valid=1; inst and pc held stable while ready=0. On valid&ready (handover):
  - next = ex_if_jump_en ? ex_if_jump_pc : pc+4 (32-bit, wraps modulo 2^32).
  - next[1:0]!=0 -> fault_pc<=next, -> FAULT with no request issued.
  - else pc<=next, -> REQ.
- ex_if_jump_en/jump_pc sampled only on the handover cycle; ignored in all other cycles.
- mem_ifu_resp_valid outside WAIT: ignored; state, inst and fault unchanged.
- FAULT: terminal until reset; all valids 0, if_fault=1, pc frozen, id_if_ready and memory inputs ignored.
- Instruction register updates only on a good response in WAIT.

## Timing
- Reset values (asserted asynchronously, held while rst_n=0): state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (nop), ifu_mem_req_valid=0, if_id_valid=0, if_fault=0, if_fault_pc=0. ifu_mem_req_addr=if_id_pc=RESET_PC.
- First request: req_valid rises on the 2nd rising edge after rst_n deasserts (IDLE->REQ on the 1st).
- Request accepted in cycle t -> WAIT from t+1. Response in cycle u>=t+1 -> if_id_valid=1 from u+1.
- Minimum throughput: one instruction per 3 cycles (REQ, WAIT, OUT) with zero-wait memory and ready=1.
- Handover in cycle h -> new PC on req_addr, req_valid=1 in cycle h+1.
- Reset mid-transaction: all state returns to reset values immediately. The outstanding response arriving after release is ignored (state not WAIT).
- Simultaneous req_ready and resp_valid in REQ: request accepted, response ignored.

## Test plan
- Reset/boot: rst_n low 3 cycles, then high -> req_valid=0 in cycle 1 after release, =1 with addr 8000_0000 in cycle 2; all outputs at reset values during reset.
- Sequential fetch, zero-wait memory, ready=1: memory returns 00000093, 00100113, 00200193 -> if_id_pc 8000_0000/8000_0004/8000_0008, one valid every 3 cycles.
- Backpressure: id_if_ready=0 for 5 cycles in OUT -> if_id_valid stays 1, inst/pc stable, no new request. Ready=1 -> next request next cycle.
- Jump: handover at pc 8000_0004 with jump_en=1, jump_pc=8000_0100 -> next req_addr=8000_0100. jump_en=1 with ready=0 -> ignored.
- Faults: resp_err on fetch of 8000_0008 -> if_fault=1, if_fault_pc=8000_0008, no further requests. Separately, jump_pc=8000_0102 -> fault with fault_pc=8000_0102, no request issued.
- Stray/overlap: resp_valid pulsed in REQ and OUT -> ignored. rst_n pulsed low during WAIT -> PC back to 8000_0000; the late response is ignored.

Source files
------------

// File: rtl/ysyx_24090013_ifu.sv
// Instruction fetch unit: owns the architectural PC, fetches one 32-bit
// instruction per transaction from instruction memory and hands the
// instruction/PC pair to decode. Next PC is pc+4 or the execute-stage jump
// target, chosen on the handover cycle. A bad response or a misaligned next
// PC parks the unit in a sticky FAULT state until reset.
module ysyx_24090013_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_mem_req_valid,
  input  logic        mem_ifu_req_ready,
  output logic [31:0] ifu_mem_req_addr,
  input  logic        mem_ifu_resp_valid,
  input  logic [31:0] mem_ifu_resp_data,
  input  logic        mem_ifu_resp_err,
  output logic        if_id_valid,
  input  logic        id_if_ready,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  input  logic        ex_if_jump_en,
  input  logic [31:0] ex_if_jump_pc,
  output logic        if_fault,
  output logic [31:0] if_fault_pc
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_fault_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_inst_nxt;
  logic [31:0] w_fault_pc_nxt;
  logic [31:0] w_target;

  // Next-state and next-datapath selection; every register holds by default.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_inst_nxt     = r_inst;
    w_fault_pc_nxt = r_fault_pc;
    // Jump inputs only matter in OUT with ready high; elsewhere w_target is unused.
    w_target       = ex_if_jump_en ? ex_if_jump_pc : (r_pc + 32'd4);
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        // A response arriving here (even alongside ready) is not ours: ignored.
        if (mem_ifu_req_ready) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_ifu_resp_valid) begin
          if (mem_ifu_resp_err) begin
            w_fault_pc_nxt = r_pc;
            w_state_nxt    = S_FAULT;
          end else begin
            w_inst_nxt  = mem_ifu_resp_data;
            w_state_nxt = S_OUT;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_OUT: begin
        if (id_if_ready) begin
          // Misaligned target never reaches the memory bus.
          if (w_target[1:0] != 2'b00) begin
            w_fault_pc_nxt = w_target;
            w_state_nxt    = S_FAULT;
          end else begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_REQ;
          end
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset to boot values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_inst     <= NOP_INST;
      r_fault_pc <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inst     <= w_inst_nxt;
      r_fault_pc <= w_fault_pc_nxt;
    end
  end

  // Outputs are decoded purely from registers: no input-to-output path.
  assign ifu_mem_req_valid = (r_state == S_REQ);
  assign ifu_mem_req_addr  = r_pc;
  assign if_id_valid       = (r_state == S_OUT);
  assign if_id_inst        = r_inst;
  assign if_id_pc          = r_pc;
  assign if_fault          = (r_state == S_FAULT);
  assign if_fault_pc       = r_fault_pc;

endmodule

// File: tb/tb_ysyx_24090013_ifu.sv
// Bench for ysyx_24090013_ifu: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level reference model.
module tb_ysyx_24090013_ifu;

  localparam logic [31:0] BOOT_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_mem_req_valid;
  logic        mem_ifu_req_ready;
  logic [31:0] ifu_mem_req_addr;
  logic        mem_ifu_resp_valid;
  logic [31:0] mem_ifu_resp_data;
  logic        mem_ifu_resp_err;
  logic        if_id_valid;
  logic        id_if_ready;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic        ex_if_jump_en;
  logic [31:0] ex_if_jump_pc;
  logic        if_fault;
  logic [31:0] if_fault_pc;

  ysyx_24090013_ifu dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ifu_mem_req_valid  (ifu_mem_req_valid),
    .mem_ifu_req_ready  (mem_ifu_req_ready),
    .ifu_mem_req_addr   (ifu_mem_req_addr),
    .mem_ifu_resp_valid (mem_ifu_resp_valid),
    .mem_ifu_resp_data  (mem_ifu_resp_data),
    .mem_ifu_resp_err   (mem_ifu_resp_err),
    .if_id_valid        (if_id_valid),
    .id_if_ready        (id_if_ready),
    .if_id_inst         (if_id_inst),
    .if_id_pc           (if_id_pc),
    .ex_if_jump_en      (ex_if_jump_en),
    .ex_if_jump_pc      (ex_if_jump_pc),
    .if_fault           (if_fault),
    .if_fault_pc        (if_fault_pc)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model: what the fetch unit is doing, in plain terms.
  bit          m_booting;    // just out of reset, request not yet raised
  bit          m_requesting; // request on the bus awaiting acceptance
  bit          m_waiting;    // request accepted, awaiting response
  bit          m_presenting; // instruction offered to decode
  bit          m_faulted;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_fpc;

  int          q_cyc[$];
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];

  // Instruction memory contents: word n above BOOT_PC encodes n (0x93, 0x00100113, ...).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BOOT_PC) >> 2;
    return (idx << 20) | (32'h0000_0093 + (idx << 7));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_booting    = 1'b1;
    m_requesting = 1'b0;
    m_waiting    = 1'b0;
    m_presenting = 1'b0;
    m_faulted    = 1'b0;
    m_pc         = BOOT_PC;
    m_inst       = 32'h0000_0013;
    m_fpc        = 32'h0000_0000;
  endtask

  task automatic model_update();
    logic [31:0] nxt;
    if (!m_faulted) begin
      if (m_booting) begin
        m_booting    = 1'b0;
        m_requesting = 1'b1;
      end else if (m_requesting) begin
        if (mem_ifu_req_ready) begin
          m_requesting = 1'b0;
          m_waiting    = 1'b1;
        end
      end else if (m_waiting) begin
        if (mem_ifu_resp_valid) begin
          m_waiting = 1'b0;
          if (mem_ifu_resp_err) begin
            m_faulted = 1'b1;
            m_fpc     = m_pc;
          end else begin
            m_inst       = mem_word(m_pc);
            m_presenting = 1'b1;
          end
        end
      end else if (m_presenting) begin
        if (id_if_ready) begin
          m_presenting = 1'b0;
          nxt = ex_if_jump_en ? ex_if_jump_pc : m_pc + 32'd4;
          if ((nxt & 32'd3) != 32'd0) begin
            m_faulted = 1'b1;
            m_fpc     = nxt;
          end else begin
            m_pc         = nxt;
            m_requesting = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("req_valid", 32'(ifu_mem_req_valid), 32'(m_requesting));
    check("req_addr",  ifu_mem_req_addr, m_pc);
    check("id_valid",  32'(if_id_valid), 32'(m_presenting));
    check("id_inst",   if_id_inst, m_inst);
    check("id_pc",     if_id_pc, m_pc);
    check("fault",     32'(if_fault), 32'(m_faulted));
    check("fault_pc",  if_fault_pc, m_fpc);
  endtask

  // Memory answers with the word at the current PC while a fetch is
  // outstanding, and with junk at any other time.
  task automatic drive_data();
    mem_ifu_resp_data = m_waiting ? mem_word(m_pc) : $urandom;
  endtask

  task automatic set_in(input bit rr, input bit rv, input bit re, input bit ir,
                        input bit je, input logic [31:0] jp);
    mem_ifu_req_ready  = rr;
    mem_ifu_resp_valid = rv;
    mem_ifu_resp_err   = re;
    id_if_ready        = ir;
    ex_if_jump_en      = je;
    ex_if_jump_pc      = jp;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    if (if_id_valid) begin
      q_cyc.push_back(cyc);
      q_pc.push_back(if_id_pc);
      q_inst.push_back(if_id_inst);
    end
    @(posedge clk);
    if (rst_n) model_update();
    cyc++;
    #1;
    drive_data();
  endtask

  // Assert reset asynchronously (called just after a rising edge), hold n cycles, release.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_reset();
    drive_data();
    check("rst_req_valid", 32'(ifu_mem_req_valid), 32'd0);
    check("rst_addr",      ifu_mem_req_addr, BOOT_PC);
    check("rst_inst",      if_id_inst, 32'h0000_0013);
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  // Move from a raised request through a good zero-wait fetch into presenting.
  task automatic fetch_out();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
  endtask

  task automatic hand(input bit je, input logic [31:0] jp);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, je, jp);
    step();
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] rnd2;
    logic [31:0] jp;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    mem_ifu_resp_data = 32'd0;
    model_reset();
    @(posedge clk);
    #1;

    // Boot and sequential fetch with zero-wait memory and constant stray responses.
    do_reset(3);
    check("boot_c1_req_valid", 32'(ifu_mem_req_valid), 32'd0);
    step();
    check("boot_c2_req_valid", 32'(ifu_mem_req_valid), 32'd1);
    check("boot_c2_addr",      ifu_mem_req_addr, 32'h8000_0000);
    q_cyc.delete(); q_pc.delete(); q_inst.delete();
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    repeat (9) step();
    check("seq_count", 32'(q_pc.size()), 32'd3);
    check("seq_pc0",   q_pc[0], 32'h8000_0000);
    check("seq_pc1",   q_pc[1], 32'h8000_0004);
    check("seq_pc2",   q_pc[2], 32'h8000_0008);
    check("seq_inst0", q_inst[0], 32'h0000_0093);
    check("seq_inst1", q_inst[1], 32'h0010_0113);
    check("seq_inst2", q_inst[2], 32'h0020_0193);
    check("seq_gap01", 32'(q_cyc[1] - q_cyc[0]), 32'd3);
    check("seq_gap12", 32'(q_cyc[2] - q_cyc[1]), 32'd3);
    check("seq_next_addr", ifu_mem_req_addr, 32'h8000_000C);

    // Backpressure with jump_en asserted while decode is not ready, then a real jump.
    do_reset(2);
    step();
    fetch_out();
    repeat (5) begin
      jp = $urandom;
      jp[1:0] = 2'b00;
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, jp);
      step();
    end
    check("bp_valid",     32'(if_id_valid), 32'd1);
    check("bp_pc",        if_id_pc, 32'h8000_0000);
    check("bp_inst",      if_id_inst, 32'h0000_0093);
    check("bp_no_req",    32'(ifu_mem_req_valid), 32'd0);
    hand(1'b0, 32'd0);
    check("bp_release_req",  32'(ifu_mem_req_valid), 32'd1);
    check("bp_release_addr", ifu_mem_req_addr, 32'h8000_0004);
    fetch_out();
    hand(1'b1, 32'h8000_0100);
    check("jump_req",  32'(ifu_mem_req_valid), 32'd1);
    check("jump_addr", ifu_mem_req_addr, 32'h8000_0100);

    // Access error on the fetch of 8000_0008.
    do_reset(2);
    step();
    fetch_out();
    hand(1'b0, 32'd0);
    fetch_out();
    hand(1'b0, 32'd0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    check("err_fault",    32'(if_fault), 32'd1);
    check("err_fault_pc", if_fault_pc, 32'h8000_0008);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0200);
    repeat (4) step();
    check("err_no_req",   32'(ifu_mem_req_valid), 32'd0);
    check("err_no_valid", 32'(if_id_valid), 32'd0);

    // Misaligned jump target.
    do_reset(2);
    step();
    fetch_out();
    hand(1'b1, 32'h8000_0102);
    check("mis_fault",    32'(if_fault), 32'd1);
    check("mis_fault_pc", if_fault_pc, 32'h8000_0102);
    check("mis_no_req",   32'(ifu_mem_req_valid), 32'd0);
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    step();
    check("mis_still_no_req", 32'(ifu_mem_req_valid), 32'd0);

    // Reset pulse during WAIT at 8000_0004; the late response must be ignored.
    do_reset(2);
    step();
    fetch_out();
    hand(1'b0, 32'd0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    drive_data();
    check("midrst_addr",      ifu_mem_req_addr, 32'h8000_0000);
    check("midrst_req_valid", 32'(ifu_mem_req_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    mem_ifu_resp_data = 32'hDEAD_BEEF;
    step();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    step();
    check("late_resp_no_valid", 32'(if_id_valid), 32'd0);
    check("late_resp_req",      32'(ifu_mem_req_valid), 32'd1);
    check("late_resp_inst",     if_id_inst, 32'h0000_0013);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom;
      if (rnd[31:23] == 9'd0 || (m_faulted && rnd[7:4] == 4'd0)) begin
        do_reset(int'(rnd[1:0]) + 1);
      end else begin
        rnd2 = $urandom;
        jp = $urandom;
        if (rnd2[15:12] != 4'd0) jp[1:0] = 2'b00;
        set_in(rnd[0], rnd[1] | rnd[2], rnd[12:8] == 5'd0, rnd[3],
               rnd[5:4] == 2'd0, jp);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
